// File: rtl/ifetch_pkg.sv
// Fetch-stage types shared by ifetch and its consumers (package pipes).
// Entry layout, FSM encoding and reset fetch address live here.
package pipes;

  typedef logic [63:0] word_t;

  localparam word_t       PCINIT_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] raw_instr;
    word_t       pc;
  } fetch_data_t;

  // Buffered entry: decode payload plus the misaligned-fetch flag.
  typedef struct packed {
    logic        exc;
    fetch_data_t data;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } ifetch_state_t;

  function automatic logic pc_misaligned(input word_t a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Generic 2-entry FIFO with flush; head is the oldest entry, valid when !empty.
// Latency: push visible at head next cycle. Backpressure: push while full needs a same-cycle pop.
module ifetch_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding bus request, 2-entry buffer to decode, redirect handling.
// Latency: response -> fd_valid next cycle. Backpressure: stops issuing while buffer is full.
// Optional IFETCH_MISALIGN_CHECK_EN: misaligned redirect targets yield an exception entry.
module ifetch
  import pipes::*;
#(
  parameter word_t PCINIT = PCINIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        fd_valid,
  input  logic        fd_ready,
  output fetch_data_t fd_data,
  output logic        fd_exc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  ifetch_state_t state, state_n;
  word_t         pc, pc_n;
  word_t         req_addr, req_addr_n;
  word_t         cur_addr;
  logic          halt, halt_n;
  logic          misal_pend, misal_pend_n;
  logic          mis_redirect;
  logic          issue_idle;
  logic          keep;
  logic          misal_push;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    occ;
  logic [1:0]    occ_after;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign mis_redirect = pc_misaligned(redirect_pc);
`else
  assign mis_redirect = 1'b0;
`endif

  // IDLE issues combinationally so a freed slot or a fresh reset costs no bubble;
  // a redirect in the same cycle suppresses it so the new target goes out next cycle.
  assign issue_idle = (state == IDLE) && !halt && !misal_pend && !fifo_full && !redirect_valid;
  assign cur_addr   = (state == IDLE) ? pc : req_addr;
  assign ireq_valid = !reset && ((state == REQ) || (state == DISCARD) || issue_idle);
  assign ireq_addr  = cur_addr;

  assign keep       = !redirect_valid && iresp_data_ok && ((state == REQ) || issue_idle);
  assign misal_push = !redirect_valid && (state == IDLE) && misal_pend;
  assign push       = keep || misal_push;
  assign pop        = fd_valid && fd_ready && !redirect_valid;

  assign occ       = {fifo_full, !fifo_full && !fifo_empty};
  assign occ_after = occ + {1'b0, push} - {1'b0, pop};

  always_comb begin
    push_entry = '0;
    if (misal_push) begin
      push_entry.exc            = 1'b1;
      push_entry.data.raw_instr = NOP_INSTR;
      push_entry.data.pc        = pc;
    end else begin
      push_entry.exc            = 1'b0;
      push_entry.data.raw_instr = iresp_data;
      push_entry.data.pc        = cur_addr;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_addr_n   = req_addr;
    halt_n       = halt;
    misal_pend_n = misal_pend;
    if (redirect_valid) begin
      pc_n         = redirect_pc;
      halt_n       = mis_redirect;
      misal_pend_n = mis_redirect;
      case (state)
        // A request still on the bus must complete before the new target goes out.
        REQ, DISCARD: state_n = iresp_data_ok ? IDLE : DISCARD;
        default:      state_n = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (misal_pend) begin
            misal_pend_n = 1'b0;
          end else if (issue_idle) begin
            req_addr_n = pc;
            state_n    = REQ;
            if (iresp_data_ok) begin
              pc_n       = pc + 64'd4;
              req_addr_n = pc + 64'd4;
              state_n    = (occ_after < 2'd2) ? REQ : IDLE;
            end
          end
        end
        REQ: begin
          if (iresp_data_ok) begin
            pc_n       = pc + 64'd4;
            req_addr_n = pc + 64'd4;
            state_n    = (occ_after < 2'd2) ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (iresp_data_ok) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= PCINIT;
      req_addr   <= PCINIT;
      halt       <= 1'b0;
      misal_pend <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_addr   <= req_addr_n;
      halt       <= halt_n;
      misal_pend <= misal_pend_n;
    end
  end

  ifetch_fifo #(
    .W($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_entry)
  );

  assign fd_valid = !fifo_empty && !reset;
  assign fd_data  = head_entry.data;
  assign fd_exc   = fd_valid && head_entry.exc;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter PCINIT, default 64'h0000_0000_8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have ports: clk  input  1  clock, the only clock; reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port ireq_valid  output  1  instruction-bus request valid.
REQ-004 SHALL have port ireq_addr  output  64  instruction-bus request address.
REQ-005 SHALL have port iresp_data_ok  input  1  response for the outstanding request is present this cycle.
REQ-006 SHALL have port iresp_data  input  32  instruction word, valid when iresp_data_ok=1.
REQ-007 SHALL have port fd_valid  output  1  fetch entry valid toward decode.
REQ-008 SHALL have port fd_ready  input  1  decode accepts the entry this cycle.
REQ-009 SHALL have port fd_data  output  96  fetch_data_t: raw_instr[31:0], pc[63:0].
REQ-010 SHALL have port fd_exc  output  1  entry carries a misaligned-fetch exception.
REQ-011 SHALL have port redirect_valid  input  1  pipeline requests a PC change this cycle.
REQ-012 SHALL have port redirect_pc  input  64  new fetch address.

Function
REQ-013 SHALL use FSM states IDLE (no request outstanding), REQ (request outstanding, response kept), DISCARD (request outstanding, response dropped).
REQ-014 SHALL hold ireq_valid=1 with ireq_addr stable from issue until the cycle iresp_data_ok=1, including across redirects.
REQ-015 SHALL, in REQ on iresp_data_ok=1, push {iresp_data, ireq_addr} into a 2-entry FIFO; entry visible on fd_valid the next cycle.
REQ-016 SHALL advance pc by 4 on every kept response; pc wraps modulo 2^64.
REQ-017 SHALL issue the next request the cycle after a response if FIFO occupancy after that cycle's push/pop is below 2; else go IDLE and issue the cycle after occupancy drops below 2.
REQ-018 SHALL pop the FIFO head when fd_valid=1 and fd_ready=1; push and pop in the same cycle with occupancy 2 are legal.
REQ-019 SHALL present fd_data and fd_exc from the FIFO head; contents are don't-care when fd_valid=0.
REQ-020 SHALL, on redirect_valid=1 in cycle t: clear the FIFO (fd_valid=0 at t+1), set pc to redirect_pc, ignore fd_ready and any push that cycle.
REQ-021 SHALL, on redirect in REQ without iresp_data_ok, enter DISCARD; the eventual response is dropped and redirect_pc is requested the following cycle.
REQ-022 SHALL, on redirect in REQ with iresp_data_ok in the same cycle, drop the response and request redirect_pc at t+1.
REQ-023 SHALL, on redirect in IDLE, request redirect_pc at t+1; on redirect in DISCARD, update pc and remain in DISCARD.
REQ-024 SHALL give redirect priority over push, pop and request issue in the same cycle.

Reset
REQ-025 SHALL, while reset=1, drive ireq_valid=0, fd_valid=0, fd_exc=0, empty the FIFO, set pc=PCINIT, state IDLE.
REQ-026 SHALL issue ireq_addr=PCINIT with ireq_valid=1 in the first cycle after reset deasserts.
REQ-027 SHALL discard any response arriving during reset; reset mid-request abandons it.

Configuration
REQ-028 SHALL, with IFETCH_MISALIGN_CHECK_EN defined, on redirect_pc[1:0]!=0 issue no bus request, enqueue {32'h0000_0013, redirect_pc} with fd_exc=1, then stay IDLE until the next redirect.
REQ-029 SHALL, without IFETCH_MISALIGN_CHECK_EN, tie fd_exc to 0 and fetch redirect_pc unchanged.

Structure
REQ-030 SHALL extend fetch_data_t in package pipes with field pc (word_t) after raw_instr.
REQ-031 SHALL define ifetch_state_t (IDLE, REQ, DISCARD) and constant PCINIT_DEFAULT in package pipes.
REQ-032 SHALL place the 2-entry buffer in sub-module ifetch_fifo (push, pop, flush, full, empty, head).

Verification
REQ-033 Reset release, bus returns data_ok one cycle after each request, fd_ready=1 -> ireq_addr 8000_0000, 8000_0004, 8000_0008; fd_data.pc in same order.
REQ-034 fd_ready=0, bus always data_ok -> exactly two entries buffered, ireq_valid=0 afterward; fd_ready=1 for one cycle -> one new request at next pc.
REQ-035 Redirect to 8000_0100 while request for 8000_0004 outstanding, data_ok 3 cycles later -> ireq_addr holds 8000_0004 until data_ok, that word never on fd, next request 8000_0100.
REQ-036 Redirect coincident with data_ok and with a pop, FIFO full -> fd_valid=0 next cycle, ireq_addr=redirect_pc next cycle.
REQ-037 With IFETCH_MISALIGN_CHECK_EN, redirect to 8000_0102 -> no bus request, fd_valid=1 with raw_instr 0000_0013, pc 8000_0102, fd_exc=1.
REQ-038 Assert reset during DISCARD -> all outputs reset-valued next cycle; first request after release is 8000_0000.
